// File: rtl/fifo_wr_arbiter.sv
// Round-robin, burst-locking write arbiter feeding a single fifo write port.
// Optional per-lane beat and stall counters are enabled with FIFO_WR_ARB_PERF_EN.
module fifo_wr_arbiter #(
  parameter int unsigned NUM_REQ    = 4,
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned MAX_BURST  = 4,
  localparam int unsigned OW        = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1,
  localparam int unsigned BW        = $clog2(MAX_BURST + 1)
) (
  input  logic                          clock,
  input  logic                          reset,
  input  logic [NUM_REQ-1:0]            req,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
  input  logic [NUM_REQ-1:0]            req_last,
  output logic [NUM_REQ-1:0]            gnt,
  input  logic                          fifo_full,
  output logic                          fifo_write_enable,
  output logic [DATA_WIDTH-1:0]         fifo_data_in,
  output logic                          busy,
  output logic [OW-1:0]                 owner_id,
  output logic [NUM_REQ*32-1:0]         perf_beats,
  output logic [31:0]                   perf_stall
);

  typedef enum logic {
    IDLE  = 1'b0,
    BURST = 1'b1
  } state_t;

  state_t          state;
  state_t          state_nxt;
  logic [OW-1:0]   last_owner;
  logic [OW-1:0]   last_nxt;
  logic [OW-1:0]   owner_nxt;
  logic [BW-1:0]   beat_cnt;
  logic [BW-1:0]   beat_nxt;
  logic [OW-1:0]   pick;
  logic            sel_req;
  logic            sel_last;
  logic [DATA_WIDTH-1:0] sel_data;

  assign sel_req  = req[owner_id];
  assign sel_last = req_last[owner_id];
  assign sel_data = req_data[32'(owner_id)*DATA_WIDTH +: DATA_WIDTH];
  assign busy     = (state == BURST);

  // First requesting lane after last_owner, wrapping; lane just served is searched last.
  always_comb begin
    pick = last_owner;
    for (int unsigned k = NUM_REQ; k >= 1; k--) begin
      int unsigned idx;
      idx = (32'(last_owner) + k) % NUM_REQ;
      if (req[OW'(idx)]) pick = OW'(idx);
    end
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      state      <= IDLE;
      last_owner <= OW'(NUM_REQ - 1);
      beat_cnt   <= '0;
      owner_id   <= '0;
    end else begin
      state      <= state_nxt;
      last_owner <= last_nxt;
      beat_cnt   <= beat_nxt;
      owner_id   <= owner_nxt;
    end
  end

  // Next-state and combinational accept path; outputs are held at zero during reset.
  always_comb begin
    state_nxt         = state;
    last_nxt          = last_owner;
    owner_nxt         = owner_id;
    beat_nxt          = beat_cnt;
    gnt               = '0;
    fifo_write_enable = 1'b0;
    fifo_data_in      = '0;
    if (reset) fifo_data_in = sel_data;
    case (state)
      IDLE: begin
        if (|req) begin
          state_nxt = BURST;
          owner_nxt = pick;
          beat_nxt  = '0;
        end
      end
      BURST: begin
        if (!sel_req) begin
          state_nxt = IDLE;
          last_nxt  = owner_id;
        end else if (!fifo_full) begin
          if (reset) begin
            gnt[owner_id]     = 1'b1;
            fifo_write_enable = 1'b1;
          end
          beat_nxt = beat_cnt + BW'(1);
          if (sel_last || (beat_cnt == BW'(MAX_BURST - 1))) begin
            state_nxt = IDLE;
            last_nxt  = owner_id;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

`ifdef FIFO_WR_ARB_PERF_EN
  logic [31:0] beats_q [NUM_REQ];
  logic [31:0] stall_q;

  // Per-lane accepted-beat counters and backpressure stall counter, free-running with wrap.
  always_ff @(posedge clock) begin
    if (!reset) begin
      for (int unsigned i = 0; i < NUM_REQ; i++) beats_q[i] <= '0;
      stall_q <= '0;
    end else begin
      for (int unsigned i = 0; i < NUM_REQ; i++) begin
        if (gnt[i]) beats_q[i] <= beats_q[i] + 32'd1;
      end
      if ((state == BURST) && sel_req && fifo_full) stall_q <= stall_q + 32'd1;
    end
  end

  for (genvar g = 0; g < NUM_REQ; g++) begin : g_perf
    assign perf_beats[g*32 +: 32] = beats_q[g];
  end
  assign perf_stall = stall_q;
`else
  assign perf_beats = '0;
  assign perf_stall = '0;
`endif

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Self-checking bench for fifo_wr_arbiter: directed scenarios plus randomized traffic
// checked against a cycle-level behavioural model of the arbitration rules.
module tb_fifo_wr_arbiter;
  localparam int unsigned N  = 4;
  localparam int unsigned DW = 8;
  localparam int unsigned MB = 4;
  localparam int unsigned OW = 2;

  logic              clock;
  logic              reset;
  logic [N-1:0]      req;
  logic [N*DW-1:0]   req_data;
  logic [N-1:0]      req_last;
  logic [N-1:0]      gnt;
  logic              fifo_full;
  logic              fifo_write_enable;
  logic [DW-1:0]     fifo_data_in;
  logic              busy;
  logic [OW-1:0]     owner_id;
  logic [N*32-1:0]   perf_beats;
  logic [31:0]       perf_stall;

  int n_chk;
  int n_fail;

  fifo_wr_arbiter #(.NUM_REQ(N), .DATA_WIDTH(DW), .MAX_BURST(MB)) dut (
    .clock(clock), .reset(reset), .req(req), .req_data(req_data), .req_last(req_last),
    .gnt(gnt), .fifo_full(fifo_full), .fifo_write_enable(fifo_write_enable),
    .fifo_data_in(fifo_data_in), .busy(busy), .owner_id(owner_id),
    .perf_beats(perf_beats), .perf_stall(perf_stall)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Reference model: who owns the fifo, how many beats taken, who was served last.
  logic          m_busy;
  logic [OW-1:0] m_owner;
  logic [OW-1:0] m_last;
  int unsigned   m_beats;
  logic [31:0]   m_perf [N];
  logic [31:0]   m_stall;

  function automatic logic [OW-1:0] rr_pick(input logic [OW-1:0] last, input logic [N-1:0] r);
    for (int unsigned k = 1; k <= N; k++) begin
      int unsigned j;
      j = (32'(last) + k) % N;
      if (r[j[OW-1:0]]) return OW'(j);
    end
    return last;
  endfunction

  always @(posedge clock) begin
    if (!reset) begin
      m_busy  <= 1'b0;
      m_owner <= '0;
      m_last  <= OW'(N - 1);
      m_beats <= 0;
      for (int i = 0; i < N; i++) m_perf[i] <= '0;
      m_stall <= '0;
    end else if (!m_busy) begin
      if (|req) begin
        m_owner <= rr_pick(m_last, req);
        m_beats <= 0;
        m_busy  <= 1'b1;
      end
    end else if (!req[m_owner]) begin
      m_busy <= 1'b0;
      m_last <= m_owner;
    end else if (fifo_full) begin
      m_stall <= m_stall + 32'd1;
    end else begin
      m_perf[m_owner] <= m_perf[m_owner] + 32'd1;
      m_beats <= m_beats + 1;
      if (req_last[m_owner] || (m_beats + 1 == MB)) begin
        m_busy <= 1'b0;
        m_last <= m_owner;
      end
    end
  end

  logic            exp_acc;
  logic [N-1:0]    exp_gnt;
  logic [DW-1:0]   exp_data;
  logic [N*32-1:0] exp_perf;
  logic [31:0]     exp_stall;

  always_comb begin
    exp_acc  = reset && m_busy && req[m_owner] && !fifo_full;
    exp_gnt  = exp_acc ? (N'(1) << m_owner) : '0;
    exp_data = reset ? req_data[32'(m_owner)*DW +: DW] : '0;
    exp_perf = '0;
    exp_stall = '0;
`ifdef FIFO_WR_ARB_PERF_EN
    for (int i = 0; i < N; i++) exp_perf[i*32 +: 32] = m_perf[i];
    exp_stall = m_stall;
`endif
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic apply_reset();
    reset = 1'b0; req = '0; req_last = '0; fifo_full = 1'b0; req_data = '0;
    tick();
    tick();
    reset = 1'b1;
  endtask

  task automatic test_reset();
    reset = 1'b0; req = 4'b1111; req_last = '0; fifo_full = 1'b0; req_data = 32'hA5C3_1E77;
    tick();
    #2;
    n_chk++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b exp 0", busy); end
    n_chk++; if (owner_id !== 2'd0) begin n_fail++; $display("FAIL reset_owner: got %0d exp 0", owner_id); end
    n_chk++; if (gnt !== 4'b0000) begin n_fail++; $display("FAIL reset_gnt: got %b exp 0000", gnt); end
    n_chk++; if (fifo_write_enable !== 1'b0) begin n_fail++; $display("FAIL reset_we: got %b exp 0", fifo_write_enable); end
    n_chk++; if (fifo_data_in !== 8'h00) begin n_fail++; $display("FAIL reset_data: got %h exp 00", fifo_data_in); end
    n_chk++; if (perf_beats !== '0 || perf_stall !== '0) begin n_fail++; $display("FAIL reset_perf: got %h/%h exp 0", perf_beats, perf_stall); end
    tick();
    reset = 1'b1;
  endtask

  task automatic test_round_robin();
    int g0, g2;
    logic [N-1:0] want;
    g0 = 0; g2 = 0;
    apply_reset();
    req = 4'b0101;
    for (int c = 0; c < 20; c++) begin
      req_data = $urandom;
      #2;
      want = ((c % 5) == 0) ? 4'b0000 : (((c / 5) % 2) == 1 ? 4'b0100 : 4'b0001);
      n_chk++; if (gnt !== want) begin n_fail++; $display("FAIL rr_pattern c%0d: got %b exp %b", c, gnt, want); end
      n_chk++; if (gnt !== exp_gnt || fifo_write_enable !== exp_acc) begin n_fail++; $display("FAIL rr_model c%0d: gnt %b we %b exp %b %b", c, gnt, fifo_write_enable, exp_gnt, exp_acc); end
      if (exp_acc) begin
        n_chk++; if (fifo_data_in !== exp_data) begin n_fail++; $display("FAIL rr_data c%0d: got %h exp %h", c, fifo_data_in, exp_data); end
      end
      g0 += int'(gnt[0]);
      g2 += int'(gnt[2]);
      tick();
    end
    n_chk++; if (g0 != 8 || g2 != 8) begin n_fail++; $display("FAIL rr_counts: got %0d/%0d exp 8/8", g0, g2); end
    n_chk++; if (perf_beats !== exp_perf || perf_stall !== exp_stall) begin n_fail++; $display("FAIL rr_perf: got %h/%h exp %h/%h", perf_beats, perf_stall, exp_perf, exp_stall); end
`ifdef FIFO_WR_ARB_PERF_EN
    n_chk++; if (perf_beats[31:0] !== 32'd8 || perf_beats[95:64] !== 32'd8) begin n_fail++; $display("FAIL rr_perf_lanes: got %0d/%0d exp 8/8", perf_beats[31:0], perf_beats[95:64]); end
`else
    n_chk++; if (perf_beats !== '0) begin n_fail++; $display("FAIL rr_perf_off: got %h exp 0", perf_beats); end
`endif
  endtask

  task automatic test_last();
    int g1;
    g1 = 0;
    apply_reset();
    for (int c = 0; c < 4; c++) begin
      req = (c < 3) ? 4'b0010 : 4'b0000;
      req_last = (c == 2) ? 4'b0010 : 4'b0000;
      #2;
      n_chk++; if (gnt !== exp_gnt) begin n_fail++; $display("FAIL last_gnt c%0d: got %b exp %b", c, gnt, exp_gnt); end
      g1 += int'(gnt[1]);
      tick();
    end
    #2;
    n_chk++; if (g1 != 2) begin n_fail++; $display("FAIL last_count: got %0d exp 2", g1); end
    n_chk++; if (busy !== 1'b0 || owner_id !== 2'd1) begin n_fail++; $display("FAIL last_release: busy %b owner %0d exp 0 1", busy, owner_id); end
  endtask

  task automatic test_backpressure();
    int g3;
    g3 = 0;
    apply_reset();
    req = 4'b1000;
    for (int c = 0; c < 10; c++) begin
      fifo_full = (c >= 3 && c < 8);
      req_data = $urandom;
      #2;
      if (fifo_full) begin
        n_chk++; if (gnt !== 4'b0000 || fifo_write_enable !== 1'b0 || busy !== 1'b1) begin n_fail++; $display("FAIL bp_hold c%0d: gnt %b we %b busy %b exp 0000 0 1", c, gnt, fifo_write_enable, busy); end
      end
      n_chk++; if (gnt !== exp_gnt) begin n_fail++; $display("FAIL bp_gnt c%0d: got %b exp %b", c, gnt, exp_gnt); end
      g3 += int'(gnt[3]);
      tick();
    end
    req = '0; fifo_full = 1'b0;
    #2;
    n_chk++; if (g3 != 4 || busy !== 1'b0) begin n_fail++; $display("FAIL bp_total: beats %0d busy %b exp 4 0", g3, busy); end
  endtask

  task automatic test_drop();
    logic [N-1:0] want [5];
    want = '{4'b0000, 4'b0001, 4'b0000, 4'b0000, 4'b0100};
    apply_reset();
    for (int c = 0; c < 5; c++) begin
      req = (c < 2) ? 4'b0101 : 4'b0100;
      #2;
      n_chk++; if (gnt !== want[c]) begin n_fail++; $display("FAIL drop_gnt c%0d: got %b exp %b", c, gnt, want[c]); end
      n_chk++; if (gnt !== exp_gnt) begin n_fail++; $display("FAIL drop_model c%0d: got %b exp %b", c, gnt, exp_gnt); end
      tick();
    end
  endtask

  task automatic test_reset_mid();
    apply_reset();
    req = 4'b0010;
    for (int c = 0; c < 6; c++) begin
      reset = (c != 3);
      if (c >= 4) req = 4'b1111;
      #2;
      if (c == 3) begin
        n_chk++; if (fifo_write_enable !== 1'b0 || gnt !== 4'b0000) begin n_fail++; $display("FAIL rstmid_we: we %b gnt %b exp 0 0000", fifo_write_enable, gnt); end
      end
      if (c == 5) begin
        n_chk++; if (gnt !== 4'b0001) begin n_fail++; $display("FAIL rstmid_first: got %b exp 0001", gnt); end
      end
      n_chk++; if (gnt !== exp_gnt) begin n_fail++; $display("FAIL rstmid_model c%0d: got %b exp %b", c, gnt, exp_gnt); end
      tick();
    end
  endtask

  task automatic test_random();
    apply_reset();
    for (int c = 0; c < 800; c++) begin
      reset     = ($urandom_range(59) != 0);
      req       = N'($urandom) | N'($urandom);
      req_last  = N'($urandom) & N'($urandom);
      fifo_full = ($urandom_range(3) == 0);
      req_data  = $urandom;
      #2;
      n_chk++; if (gnt !== exp_gnt) begin n_fail++; $display("FAIL rnd_gnt c%0d: got %b exp %b", c, gnt, exp_gnt); end
      n_chk++; if (fifo_write_enable !== exp_acc) begin n_fail++; $display("FAIL rnd_we c%0d: got %b exp %b", c, fifo_write_enable, exp_acc); end
      if (exp_acc || !reset) begin
        n_chk++; if (fifo_data_in !== exp_data) begin n_fail++; $display("FAIL rnd_data c%0d: got %h exp %h", c, fifo_data_in, exp_data); end
      end
      n_chk++; if (busy !== m_busy || owner_id !== m_owner) begin n_fail++; $display("FAIL rnd_state c%0d: busy %b owner %0d exp %b %0d", c, busy, owner_id, m_busy, m_owner); end
      n_chk++; if (perf_beats !== exp_perf || perf_stall !== exp_stall) begin n_fail++; $display("FAIL rnd_perf c%0d: got %h/%h exp %h/%h", c, perf_beats, perf_stall, exp_perf, exp_stall); end
      tick();
    end
  endtask

  initial begin
    n_chk = 0; n_fail = 0;
    reset = 1'b0; req = '0; req_last = '0; fifo_full = 1'b0; req_data = '0;
    test_reset();
    test_round_robin();
    test_last();
    test_backpressure();
    test_drop();
    test_reset_mid();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/fifo_wr_arbiter.md
Name: fifo_wr_arbiter

Overview:
- Round-robin, burst-locking write arbiter that shares one fifo instance (write side) among N producer lanes of the accelerator, e.g. parallel NTT/MSM result lanes.
- Holds a grant for a bounded burst so each lane's beats land contiguously in the fifo.
- Respects the fifo's early full flag.
- Sits directly in front of the fifo's write_enable/data_in/full ports.

Parameters:
- NUM_REQ, 4, number of requesting lanes (2..16).
- DATA_WIDTH, 8, beat width; must match the downstream fifo DATA_WIDTH.
- MAX_BURST, 4, maximum beats per grant before forced rotation (1..255).

Ports:
- clock  in  1  single clock; all logic on rising edge.
- reset  in  1  synchronous, active-low reset.
- req  in  NUM_REQ  per-lane request: lane has a valid beat.
- req_data  in  NUM_REQ*DATA_WIDTH  lane i beat at bits [i*DATA_WIDTH +: DATA_WIDTH].
- req_last  in  NUM_REQ  lane's current beat is the final beat of its packet.
- gnt  out  NUM_REQ  one-hot accept strobe; beat taken this cycle.
- fifo_full  in  1  fifo full flag.
- fifo_write_enable  out  1  drives fifo write_enable.
- fifo_data_in  out  DATA_WIDTH  drives fifo data_in.
- busy  out  1  a burst is owned (state BURST).
- owner_id  out  max(1,$clog2(NUM_REQ))  current or most recent owner index.

Behaviour:
- Reset (reset==0 at edge): state=IDLE, last_owner=NUM_REQ-1 (lane 0 wins first), beat_cnt=0, owner_id=0, busy=0. gnt, fifo_write_enable and fifo_data_in are 0 while reset is low.
- States: IDLE, BURST.
- IDLE:
  - No beats are transferred; gnt=0, fifo_write_enable=0.
  - If any req is set, pick the first set bit searching from last_owner+1 upward, modulo NUM_REQ.
  - Register that index as owner, clear beat_cnt, go to BURST.
  - Arbitration costs exactly one bubble cycle per burst.
- BURST:
  - accept = req[owner] & ~fifo_full, combinational. gnt[owner]=accept; all other gnt bits are 0.
  - fifo_write_enable=accept; fifo_data_in=req_data[owner] (mux on owner is valid even when not accepting).
  - On accept: beat_cnt+1. If req_last[owner] or beat_cnt==MAX_BURST-1, go to IDLE and set last_owner=owner.
  - If req[owner]==0: release immediately with no transfer. Go to IDLE, last_owner=owner.
  - If fifo_full==1 and req[owner]==1: hold in BURST, no gnt, beat_cnt unchanged. Ownership is not lost on backpressure.
- Requesters must hold req/req_data/req_last stable until gnt. A lane may drop req at any time; dropping releases the grant.
- Simultaneous requests: strict round-robin; a lane just served has lowest priority next arbitration.
- Single requester: re-granted every IDLE pass (gap of one cycle between bursts).
- beat_cnt width is $clog2(MAX_BURST+1); it never exceeds MAX_BURST-1 while in BURST.
- Reset low mid-burst: abort immediately, no write that cycle, back to IDLE with lane 0 priority.
- busy=1 exactly while in BURST. owner_id is updated on entry to BURST and held through IDLE.

Optional Feature:
- Macro FIFO_WR_ARB_PERF_EN adds output perf_beats, NUM_REQ*32 bits: per-lane count of accepted beats. The counter for lane i increments on gnt[i], wraps at 2^32, and is cleared by reset.
- Adds output perf_stall, 32 bits: count of BURST cycles with req[owner]&fifo_full. Wraps at 2^32, cleared by reset.
- Without the macro: both ports still exist, tied to 0, and no counter flops are built.

Test Plan:
- After reset release, req=4'b0101, all req_last=0, fifo_full=0. Expected: cycle 1 IDLE bubble; lane 0 gets 4 gnt cycles; bubble; lane 2 gets 4; then lane 0 again.
- Lane 1 only, req_last on its 2nd beat. Expected: gnt[1] for exactly 2 cycles, busy falls the next cycle, owner_id=1 held.
- Lane 3 in BURST, fifo_full=1 for 5 cycles mid-burst. Expected: no gnt and no fifo_write_enable for those 5 cycles, burst resumes with beat_cnt preserved, total 4 beats.
- Lane 0 owner drops req after 1 beat while lane 2 requests. Expected: release with no transfer, IDLE bubble, lane 2 granted.
- reset=0 asserted during lane 1's 3rd beat. Expected: fifo_write_enable=0 that cycle; after release with req=4'b1111, lane 0 is granted first.
- With FIFO_WR_ARB_PERF_EN: the first scenario for 20 cycles yields perf_beats lane0=8, lane2=8 (±1 for the final partial burst, computed exactly by the bench model). Without the macro, all perf outputs are 0.
